// File: rtl/switch_decode.sv
// Debounces a 2-bit switch code into a registered IDLE/ON/OFF/FAULT state with a saturating error counter.
// Define SWITCH_DECODE_CHECK_EN to also check the lagging num companion against the previous sampled code.
module switch_decode #(
    parameter int STABLE_CYCLES = 3,
    parameter int FAULT_LIMIT   = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       code,
    input  logic [2:0]       num,
    input  logic             clr_err,
    output logic             state_out,
    output logic             state_vld,
    output logic             changed,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FAULT} state_t;

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] FAULT_MAX  = 4'(FAULT_LIMIT);

    localparam logic [1:0] CODE_IDLE    = 2'h0;
    localparam logic [1:0] CODE_ON      = 2'h1;
    localparam logic [1:0] CODE_ILLEGAL = 2'h2;
    localparam logic [1:0] CODE_OFF     = 2'h3;

    state_t           state, state_nxt;
    logic [1:0]       cand;
    logic [3:0]       stab_cnt, stab_nxt;
    logic [3:0]       ill_cnt, ill_nxt;
    logic             prev_vld;
    logic             illegal, accept, fault_hit, restart, mismatch, err_event;
    logic             state_out_nxt, state_vld_nxt, changed_nxt, fault_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;

    // Candidate always follows the sample, so between edges it equals the previous sampled code.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stab_nxt  = 4'd1;
        ill_nxt   = 4'd0;
        illegal   = (code == CODE_ILLEGAL);
        if (stab_cnt != 4'd0 && code == cand)
            stab_nxt = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + 4'd1;
        if (illegal)
            ill_nxt = (ill_cnt == FAULT_MAX) ? ill_cnt : ill_cnt + 4'd1;
        accept    = (stab_nxt == STABLE_MAX);
        fault_hit = (ill_nxt == FAULT_MAX);
        restart   = (state == S_FAULT) && clr_err;
    end

`ifdef SWITCH_DECODE_CHECK_EN
    logic [2:0] exp_num;

    always_comb begin
        exp_num = 3'h0;
        case (cand)
            CODE_ON:  exp_num = 3'h2;
            CODE_OFF: exp_num = 3'h4;
            default:  exp_num = 3'h0;
        endcase
        mismatch = prev_vld && (cand != CODE_ILLEGAL) && (num != exp_num);
    end
`else
    logic unused_sig;

    assign mismatch   = 1'b0;
    assign unused_sig = ^{num, prev_vld};
`endif

    always_comb begin
        state_nxt     = state;
        state_out_nxt = state_out;
        case (state)
            S_FAULT: begin
                if (clr_err)
                    state_nxt = S_IDLE;
            end
            default: begin
                if (fault_hit) begin
                    state_nxt = S_FAULT;
                end else if (accept) begin
                    case (code)
                        CODE_ON:   state_nxt = S_ON;
                        CODE_OFF:  state_nxt = S_OFF;
                        CODE_IDLE: state_nxt = S_IDLE;
                        default:   state_nxt = state;
                    endcase
                end
            end
        endcase

        case (state_nxt)
            S_ON:    state_out_nxt = 1'b0;
            S_OFF:   state_out_nxt = 1'b1;
            default: state_out_nxt = state_out;
        endcase
        state_vld_nxt = (state_nxt == S_ON) || (state_nxt == S_OFF);
        changed_nxt   = state_vld_nxt && (state_nxt != state);
        fault_nxt     = (state_nxt == S_FAULT);
    end

    // Clear beats a coincident error; one increment per edge regardless of how many causes.
    always_comb begin
        err_event   = illegal || mismatch;
        err_cnt_nxt = err_cnt;
        if (clr_err)
            err_cnt_nxt = '0;
        else if (err_event && err_cnt != '1)
            err_cnt_nxt = err_cnt + ERR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state, including counters, is reset asynchronously; there is no memory array here.
        if (!rst) begin
            state     <= S_IDLE;
            cand      <= CODE_IDLE;
            stab_cnt  <= 4'd0;
            ill_cnt   <= 4'd0;
            prev_vld  <= 1'b0;
            state_out <= 1'b0;
            state_vld <= 1'b0;
            changed   <= 1'b0;
            fault     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cand      <= code;
            stab_cnt  <= restart ? 4'd0 : stab_nxt;
            ill_cnt   <= restart ? 4'd0 : ill_nxt;
            prev_vld  <= 1'b1;
            state_out <= state_out_nxt;
            state_vld <= state_vld_nxt;
            changed   <= changed_nxt;
            fault     <= fault_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_switch_decode.sv
// Self-checking bench for switch_decode: directed scenarios plus random stimulus against an integer reference model.
// Two instances run in lockstep: default parameters and a narrow-counter/long-fault-limit variant.
module tb_switch_decode;

    localparam int S  = 3;
    localparam int L1 = 4;
    localparam int W1 = 8;
    localparam int L2 = 15;
    localparam int W2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] code = 2'h0;
    logic [2:0] num = 3'h0;
    logic       clr_err = 1'b0;

    logic d1_so, d1_vld, d1_chg, d1_flt;
    logic [W1-1:0] d1_err;
    logic d2_so, d2_vld, d2_chg, d2_flt;
    logic [W2-1:0] d2_err;

    logic [W1+3:0] obs1;
    logic [W2+3:0] obs2;
    assign obs1 = {d1_so, d1_vld, d1_chg, d1_flt, d1_err};
    assign obs2 = {d2_so, d2_vld, d2_chg, d2_flt, d2_err};

    switch_decode #(.STABLE_CYCLES(S), .FAULT_LIMIT(L1), .ERR_W(W1)) dut1 (
        .clk(clk), .rst(rst), .code(code), .num(num), .clr_err(clr_err),
        .state_out(d1_so), .state_vld(d1_vld), .changed(d1_chg), .fault(d1_flt), .err_cnt(d1_err)
    );

    switch_decode #(.STABLE_CYCLES(S), .FAULT_LIMIT(L2), .ERR_W(W2)) dut2 (
        .clk(clk), .rst(rst), .code(code), .num(num), .clr_err(clr_err),
        .state_out(d2_so), .state_vld(d2_vld), .changed(d2_chg), .fault(d2_flt), .err_cnt(d2_err)
    );

    always #5 clk = ~clk;

    // Reference model: st 0 IDLE, 1 ON, 2 OFF, 3 FAULT; run lengths are unbounded integers.
    typedef struct {
        int last_code;
        int run;
        int ill_run;
        int st;
        bit so, vld, chg, flt;
        int err;
        bit have_prev;
    } model_t;

    model_t m1, m2;
    int vectors = 0;
    int miscompares = 0;
    int last_c = 0;

    function automatic int comp(int c);
        if (c == 1) return 2;
        if (c == 3) return 4;
        return 0;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.last_code = 0; r.run = 0; r.ill_run = 0; r.st = 0;
        r.so = 0; r.vld = 0; r.chg = 0; r.flt = 0; r.err = 0; r.have_prev = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, int c, int n, bit clr, int lim, int emax);
        model_t r = m;
        int ns;
        bit bad;
        bad = (c == 2);
`ifdef SWITCH_DECODE_CHECK_EN
        if (m.have_prev && m.last_code != 2 && n != comp(m.last_code)) bad = 1;
`else
        if (n < 0) bad = 1;
`endif
        r.run     = (m.run == 0 || c != m.last_code) ? 1 : m.run + 1;
        r.ill_run = (c == 2) ? m.ill_run + 1 : 0;
        ns = m.st;
        if (m.st == 3) begin
            if (clr) begin ns = 0; r.run = 0; r.ill_run = 0; end
        end else if (r.ill_run >= lim) begin
            ns = 3;
        end else if (r.run >= S) begin
            if (c == 1) ns = 1;
            else if (c == 3) ns = 2;
            else if (c == 0) ns = 0;
        end
        r.vld = (ns == 1 || ns == 2);
        r.chg = r.vld && (ns != m.st);
        r.flt = (ns == 3);
        if (ns == 1) r.so = 0;
        if (ns == 2) r.so = 1;
        if (clr) r.err = 0;
        else if (bad && m.err < emax) r.err = m.err + 1;
        r.st = ns; r.last_code = c; r.have_prev = 1;
        return r;
    endfunction

    function automatic logic [W1+3:0] exp1();
        return {m1.so, m1.vld, m1.chg, m1.flt, W1'(m1.err)};
    endfunction

    function automatic logic [W2+3:0] exp2();
        return {m2.so, m2.vld, m2.chg, m2.flt, W2'(m2.err)};
    endfunction

    // Drives one cycle from a negedge, advances both models at the posedge, returns at the next negedge.
    task automatic drive_cycle(input int c, input int n, input bit clr);
        code = 2'(c); num = 3'(n); clr_err = clr;
        @(posedge clk);
        m1 = model_step(m1, c, n, clr, L1, (1 << W1) - 1);
        m2 = model_step(m2, c, n, clr, L2, (1 << W2) - 1);
        last_c = c;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (obs1 !== '0) begin miscompares++; $display("FAIL reset dut1 got %h want 0", obs1); end
        vectors++;
        if (obs2 !== '0) begin miscompares++; $display("FAIL reset dut2 got %h want 0", obs2); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        m1 = model_reset(); m2 = model_reset(); last_c = 0;
    endtask

    task automatic test_accept();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1, (i == 1) ? 0 : 2, 0);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL accept edge%0d dut1 got %h want %h", i, obs1, exp1()); end
            vectors++;
            if (d1_chg !== (i == 3)) begin miscompares++; $display("FAIL accept_changed edge%0d got %b want %b", i, d1_chg, (i == 3)); end
        end
        vectors++;
        if ({d1_vld, d1_so, d1_err} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++; $display("FAIL accept_final got vld=%b out=%b err=%0d want vld=1 out=0 err=0", d1_vld, d1_so, d1_err);
        end
    endtask

    task automatic test_glitch();
        int cs[5] = '{3, 1, 1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(cs[i], comp(last_c), 0);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL glitch cyc%0d dut1 got %h want %h", i, obs1, exp1()); end
            vectors++;
            if ({d1_chg, d1_vld, d1_so} !== 3'b010) begin
                miscompares++; $display("FAIL glitch_hold cyc%0d got chg/vld/out=%b want 010", i, {d1_chg, d1_vld, d1_so});
            end
        end
    endtask

    task automatic test_fault();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(2, comp(last_c), 0);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL fault edge%0d dut1 got %h want %h", i, obs1, exp1()); end
            vectors++;
            if (d1_flt !== (i == 4)) begin miscompares++; $display("FAIL fault_timing edge%0d got %b want %b", i, d1_flt, (i == 4)); end
        end
        vectors++;
        if (d1_err !== 8'd4) begin miscompares++; $display("FAIL fault_err got %0d want 4", d1_err); end
        drive_cycle(0, 0, 1);
        vectors++;
        if ({d1_flt, d1_vld, d1_err} !== {1'b0, 1'b0, 8'h00}) begin
            miscompares++; $display("FAIL fault_clear got flt=%b vld=%b err=%0d want 0 0 0", d1_flt, d1_vld, d1_err);
        end
        vectors++;
        if (obs2 !== exp2()) begin miscompares++; $display("FAIL fault_clear dut2 got %h want %h", obs2, exp2()); end
        drive_cycle(0, 0, 0);
    endtask

    task automatic test_num_check();
        int want;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(3, 0, 0);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL numchk cyc%0d dut1 got %h want %h", i, obs1, exp1()); end
            vectors++;
            if (obs2 !== exp2()) begin miscompares++; $display("FAIL numchk cyc%0d dut2 got %h want %h", i, obs2, exp2()); end
        end
`ifdef SWITCH_DECODE_CHECK_EN
        want = 5;
`else
        want = 0;
`endif
        vectors++;
        if (d1_err !== 8'(want)) begin miscompares++; $display("FAIL numchk_err got %0d want %0d", d1_err, want); end
        drive_cycle(3, 4, 1);
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(2, $urandom_range(0, 7), 0);
            vectors++;
            if (obs2 !== exp2()) begin miscompares++; $display("FAIL saturate edge%0d dut2 got %h want %h", i, obs2, exp2()); end
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL saturate edge%0d dut1 got %h want %h", i, obs1, exp1()); end
        end
        vectors++;
        if ({d2_flt, d2_err} !== 3'b111) begin
            miscompares++; $display("FAIL saturate_final got flt=%b err=%0d want flt=1 err=3", d2_flt, d2_err);
        end
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, comp(last_c), 0);
        drive_cycle(1, 2, 0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs1 !== '0) begin miscompares++; $display("FAIL reset_mid dut1 got %h want 0", obs1); end
        vectors++;
        if (obs2 !== '0) begin miscompares++; $display("FAIL reset_mid dut2 got %h want 0", obs2); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({obs1, obs2} !== '0) begin miscompares++; $display("FAIL reset_hold cyc%0d got %h/%h want 0", i, obs1, obs2); end
        end
        rst = 1'b1;
        m1 = model_reset(); m2 = model_reset(); last_c = 0;
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1, comp(last_c), 0);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL reset_rearm edge%0d dut1 got %h want %h", i, obs1, exp1()); end
        end
    endtask

    task automatic test_random();
        int c, n;
        bit clr;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) c = last_c;
            else c = $urandom_range(0, 3);
            n   = ($urandom_range(0, 9) != 0) ? comp(last_c) : int'($urandom_range(0, 7));
            clr = ($urandom_range(0, 29) == 0);
            drive_cycle(c, n, clr);
            vectors++;
            if (obs1 !== exp1()) begin miscompares++; $display("FAIL random cyc%0d dut1 got %h want %h", i, obs1, exp1()); end
            vectors++;
            if (obs2 !== exp2()) begin miscompares++; $display("FAIL random cyc%0d dut2 got %h want %h", i, obs2, exp2()); end
        end
    endtask

    initial begin
        m1 = model_reset();
        m2 = model_reset();
        @(negedge clk);
        test_reset();
        test_accept();
        test_glitch();
        test_fault();
        test_num_check();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
